unpacked_array_serializer: RTL and testbench
============================================

UNPACKED_ARRAY_SERIALIZER -- requirements
Module: unpacked_array_serializer

Interface
REQ-001 Parameter M, default 2, meaning number of elements in the unpacked input array; legal range 1..64.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-004 in_valid  input  1  upstream word present on in_data.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  logic unpacked array [0:M-1] of 1 bit  word from the upstream stage, element 0 first in index order.
REQ-007 out_valid  output  1  out_bit holds a valid beat.
REQ-008 out_ready  input  1  downstream accepts the current beat.
REQ-009 out_bit  output  1  serialized data beat.
REQ-010 out_last  output  1  current beat is the final beat of the word.

Function
REQ-011 FSM states IDLE, SHIFT, PARITY (PARITY only when the Configuration macro is defined).
REQ-012 in_ready SHALL be 1 only in IDLE; in_valid && in_ready captures all M elements into an internal register and moves to SHIFT next cycle.
REQ-013 Latency: first beat SHALL be presented with out_valid=1 on the cycle after capture; in_data changes after capture SHALL have no effect.
REQ-014 In SHIFT, out_bit SHALL equal captured element[idx], idx starting at 0 and ascending to M-1.
REQ-015 A beat SHALL advance only on out_valid && out_ready; while out_ready=0, out_bit, out_last and idx SHALL hold.
REQ-016 idx counter width SHALL be max(1, clog2(M)); it SHALL never exceed M-1 and SHALL reset to 0 on each capture.
REQ-017 Without parity, out_last=1 when idx=M-1; acceptance of that beat returns FSM to IDLE.
REQ-018 M=1: word SHALL be emitted as a single beat with out_last=1.
REQ-019 One idle cycle (in_ready=1, out_valid=0) SHALL separate consecutive words; no back-to-back overlap.
REQ-020 out_valid SHALL be 0 in IDLE; out_bit and out_last SHALL be 0 whenever out_valid=0.

Reset
REQ-021 reset_n=0 at a rising edge SHALL force IDLE, idx=0, captured register=0, out_valid=0, out_bit=0, out_last=0, in_ready=1 from the next cycle.
REQ-022 Reset asserted mid-word SHALL abandon the word; no remaining beats emitted after reset release.

Configuration
REQ-023 Macro UNPACKED_SERIALIZER_PARITY_EN: when defined, after element M-1 is accepted the FSM SHALL enter PARITY and emit one extra beat equal to the XOR of all M captured elements (even parity) with out_last=1; out_last SHALL then be 0 on element M-1.
REQ-024 When undefined, PARITY state and its logic SHALL not exist; each word is exactly M beats.

Structure
REQ-025 Shared package unpacked_serializer_pkg SHALL hold the FSM state enum typedef and a max(1, clog2(M)) width function.
REQ-026 No sub-module; a single module with FSM, capture register and index counter.

Verification
REQ-027 M=4, in_data={1,0,1,1}, out_ready=1 -> out_bit 1,0,1,1 on 4 consecutive cycles starting cycle after capture, out_last on 4th beat only.
REQ-028 M=4, same word, out_ready low for 3 cycles on beat 2 -> out_bit=0 held 3 cycles, no beat lost or duplicated.
REQ-029 M=1, in_data={1} -> single beat out_bit=1, out_last=1, in_ready back to 1 next cycle.
REQ-030 M=4, reset_n=0 during beat 2 -> next cycle out_valid=0, in_ready=1; next word {0,0,0,1} emitted cleanly from element 0.
REQ-031 PARITY_EN defined, M=4, in_data={1,0,1,1} -> 5 beats 1,0,1,1,1; out_last on beat 5 only.
REQ-032 Two words offered back-to-back with in_valid held 1 -> second captured only after one-cycle IDLE gap; in_ready=0 throughout SHIFT.

Source files
------------

// File: rtl/unpacked_serializer_pkg.sv
// Shared types and helpers for unpacked_array_serializer.
// Optional macro UNPACKED_SERIALIZER_PARITY_EN adds the trailing parity state.
package unpacked_serializer_pkg;

`ifdef UNPACKED_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    // Index counter width; a single-element word still needs one bit.
    function automatic int idx_width(input int m);
        int w;
        w = $clog2(m);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/unpacked_array_serializer.sv
// Captures an M-element unpacked bit array and emits it one bit per beat, element 0 first.
// Macro UNPACKED_SERIALIZER_PARITY_EN appends one even-parity beat to each word.
module unpacked_array_serializer
    import unpacked_serializer_pkg::*;
#(
    parameter int M = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_data [0:M-1],
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_last
);

    localparam int             W        = idx_width(M);
    localparam logic [W-1:0]   LAST_IDX = W'(M - 1);

    state_t         r_state,  w_state_nxt;
    logic [W-1:0]   r_idx,    w_idx_nxt;
    logic           r_data     [0:M-1];
    logic           w_data_nxt [0:M-1];
    logic           r_in_ready,  w_in_ready_nxt;
    logic           r_out_valid, w_out_valid_nxt;
    logic           r_out_bit,   w_out_bit_nxt;
    logic           r_out_last,  w_out_last_nxt;

`ifdef UNPACKED_SERIALIZER_PARITY_EN
    function automatic logic parity_of(input logic d [0:M-1]);
        logic p;
        p = 1'b0;
        for (int i = 0; i < M; i++) begin
            p = p ^ d[i];
        end
        return p;
    endfunction
`endif

    // Next-state, index, capture and next output values.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_data_nxt      = r_data;
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_out_bit_nxt   = 1'b0;
        w_out_last_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_data_nxt  = in_data;
                    w_idx_nxt   = W'(0);
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (out_ready && (r_idx == LAST_IDX)) begin
`ifdef UNPACKED_SERIALIZER_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end else if (out_ready) begin
                    w_idx_nxt = r_idx + W'(1);
                end else begin
                    w_idx_nxt = r_idx;
                end
            end
`ifdef UNPACKED_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_PARITY;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        case (w_state_nxt)
            ST_IDLE: begin
                w_in_ready_nxt = 1'b1;
            end
            ST_SHIFT: begin
                w_out_valid_nxt = 1'b1;
                w_out_bit_nxt   = w_data_nxt[w_idx_nxt];
`ifdef UNPACKED_SERIALIZER_PARITY_EN
                w_out_last_nxt  = 1'b0;
`else
                w_out_last_nxt  = (w_idx_nxt == LAST_IDX);
`endif
            end
`ifdef UNPACKED_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                w_out_valid_nxt = 1'b1;
                w_out_bit_nxt   = parity_of(w_data_nxt);
                w_out_last_nxt  = 1'b1;
            end
`endif
            default: begin
                w_in_ready_nxt = 1'b0;
            end
        endcase
    end

    // State, capture register, index and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= W'(0);
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
            for (int i = 0; i < M; i++) begin
                r_data[i] <= 1'b0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_bit   <= w_out_bit_nxt;
            r_out_last  <= w_out_last_nxt;
            for (int i = 0; i < M; i++) begin
                r_data[i] <= w_data_nxt[i];
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_bit   = r_out_bit;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_unpacked_array_serializer.sv
// Directed bench for unpacked_array_serializer with M=4 and M=1 instances.
// Parity expectations follow UNPACKED_SERIALIZER_PARITY_EN.
module tb_unpacked_array_serializer;

`ifdef UNPACKED_SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;
    logic out_ready;
    logic in_valid;
    logic in_data [0:3];
    logic in_valid1;
    logic in_data1 [0:0];

    logic in_ready, out_valid, out_bit, out_last;
    logic in_ready1, out_valid1, out_bit1, out_last1;

    int errors = 0;
    int checks = 0;

    unpacked_array_serializer #(.M(4)) dut4 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last)
    );

    unpacked_array_serializer #(.M(1)) dut1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_bit   (out_bit1),
        .out_last  (out_last1)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bit !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_m4: ready=%b valid=%b bit=%b last=%b, required 1 0 0 0",
                     in_ready, out_valid, out_bit, out_last);
        end
        checks++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || out_bit1 !== 1'b0 || out_last1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_m1: ready=%b valid=%b bit=%b last=%b, required 1 0 0 0",
                     in_ready1, out_valid1, out_bit1, out_last1);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic exp [0:3];
        exp = '{1'b1, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        in_data   = exp;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_bit !== exp[k] || out_last !== ((k == 3) && !PAR) || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL basic_beat%0d: valid=%b bit=%b last=%b ready=%b, required 1 %b %b 0",
                         k, out_valid, out_bit, out_last, in_ready, exp[k], (k == 3) && !PAR);
            end
            step();
        end
`ifdef UNPACKED_SERIALIZER_PARITY_EN
        checks++;
        if (out_valid !== 1'b1 || out_bit !== 1'b1 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL basic_parity: valid=%b bit=%b last=%b, required 1 1 1", out_valid, out_bit, out_last);
        end
        step();
`endif
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bit !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: valid=%b ready=%b bit=%b last=%b, required 0 1 0 0",
                     out_valid, in_ready, out_bit, out_last);
        end
    endtask

    task automatic test_stall();
        in_data  = '{1'b1, 1'b0, 1'b1, 1'b1};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_bit !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_beat0: bit=%b valid=%b, required 1 1", out_bit, out_valid);
        end
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_bit !== 1'b0 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b bit=%b last=%b, required 1 0 0",
                         c, out_valid, out_bit, out_last);
            end
            if (c < 2) step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_bit !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL stall_beat2: bit=%b last=%b, required 1 0", out_bit, out_last);
        end
        step();
        checks++;
        if (out_bit !== 1'b1 || out_last !== !PAR || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_beat3: bit=%b last=%b valid=%b, required 1 %b 1", out_bit, out_last, out_valid, !PAR);
        end
        step();
`ifdef UNPACKED_SERIALIZER_PARITY_EN
        step();
`endif
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_end: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_m1();
        in_data1  = '{1'b1};
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        in_data1  = '{1'b0};
        checks++;
        if (out_valid1 !== 1'b1 || out_bit1 !== 1'b1 || out_last1 !== !PAR || in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL m1_beat: valid=%b bit=%b last=%b ready=%b, required 1 1 %b 0",
                     out_valid1, out_bit1, out_last1, in_ready1, !PAR);
        end
        step();
`ifdef UNPACKED_SERIALIZER_PARITY_EN
        checks++;
        if (out_valid1 !== 1'b1 || out_bit1 !== 1'b1 || out_last1 !== 1'b1) begin
            errors++;
            $display("FAIL m1_parity: valid=%b bit=%b last=%b, required 1 1 1", out_valid1, out_bit1, out_last1);
        end
        step();
`endif
        checks++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL m1_idle: ready=%b valid=%b, required 1 0", in_ready1, out_valid1);
        end
    endtask

    task automatic test_reset_mid();
        logic exp [0:3];
        in_data  = '{1'b1, 1'b0, 1'b1, 1'b1};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bit !== 1'b0) begin
            errors++;
            $display("FAIL midreset: valid=%b ready=%b bit=%b, required 0 1 0", out_valid, in_ready, out_bit);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_quiet: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        exp      = '{1'b0, 1'b0, 1'b0, 1'b1};
        in_data  = exp;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_bit !== exp[k] || out_last !== ((k == 3) && !PAR)) begin
                errors++;
                $display("FAIL midreset_beat%0d: valid=%b bit=%b last=%b, required 1 %b %b",
                         k, out_valid, out_bit, out_last, exp[k], (k == 3) && !PAR);
            end
            step();
        end
`ifdef UNPACKED_SERIALIZER_PARITY_EN
        checks++;
        if (out_bit !== 1'b1 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL midreset_parity: bit=%b last=%b, required 1 1", out_bit, out_last);
        end
        step();
`endif
    endtask

    task automatic test_back_to_back();
        logic exp_a [0:3];
        logic exp_b [0:3];
        exp_a    = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_b    = '{1'b0, 1'b1, 1'b1, 1'b0};
        in_data  = exp_a;
        in_valid = 1'b1;
        step();
        in_data = exp_b;
        for (int k = 0; k < 4 + int'(PAR); k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || (k < 4 && out_bit !== exp_a[k])) begin
                errors++;
                $display("FAIL b2b_a%0d: ready=%b valid=%b bit=%b, required 0 1 %b",
                         k, in_ready, out_valid, out_bit, (k < 4) ? exp_a[k] : 1'b1);
            end
            step();
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_bit !== exp_b[k] || out_last !== ((k == 3) && !PAR)) begin
                errors++;
                $display("FAIL b2b_b%0d: ready=%b bit=%b last=%b, required 0 %b %b",
                         k, in_ready, out_bit, out_last, exp_b[k], (k == 3) && !PAR);
            end
            step();
        end
`ifdef UNPACKED_SERIALIZER_PARITY_EN
        checks++;
        if (out_bit !== 1'b0 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_parity: bit=%b last=%b, required 0 1", out_bit, out_last);
        end
        step();
`endif
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        in_data   = '{1'b0, 1'b0, 1'b0, 1'b0};
        in_data1  = '{1'b0};
        test_reset();
        test_basic();
        test_stall();
        test_m1();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
